// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: start/operand and result bundle between the decoder
// side (master) and the iterative multiply/divide unit (slave).
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, stall, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, stall, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULTU/DIVU unit owning the HI/LO registers.
// One shift-add (multiply) or restoring trial-subtract (divide) step per
// cycle; hi/lo change only on the commit edge.
// Optional macro MULDIV_EARLY_OUT_EN: MULTU finishes as soon as the
// remaining multiplier bits are all zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic                 accept, commit, last;

  logic                 op_q;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     rem, quot, divisor;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 dbz_q;

  logic [2*WIDTH-1:0]   acc_nxt, mcand_nxt;
  logic [WIDTH-1:0]     mplier_nxt;
  logic [WIDTH:0]       trial, diff;
  logic [WIDTH-1:0]     rem_nxt, quot_nxt;

  // One iteration of both datapaths; op_q selects which result commits.
  // The remainder register keeps only WIDTH bits: the extra trial bit is
  // rebuilt each step from rem's MSB, and a set trial MSB always means the
  // subtraction cannot go negative (keeps divide-by-zero yielding all ones).
  always_comb begin
    acc_nxt    = mplier[0] ? acc + mcand : acc;
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
    trial      = {rem, quot[WIDTH-1]};
    diff       = trial - {1'b0, divisor};
    if (trial[WIDTH] || !diff[WIDTH]) begin
      rem_nxt  = diff[WIDTH-1:0];
      quot_nxt = {quot[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt  = trial[WIDTH-1:0];
      quot_nxt = {quot[WIDTH-2:0], 1'b0};
    end
`ifdef MULDIV_EARLY_OUT_EN
    last = (cnt == CW'(WIDTH - 1)) || (!op_q && (mplier_nxt == '0));
`else
    last = (cnt == CW'(WIDTH - 1));
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and launch/commit strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last) begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch and per-cycle iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
    end else if (accept) begin
      op_q    <= bus.op;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, bus.a};
      mplier  <= bus.b;
      rem     <= '0;
      quot    <= bus.a;
      divisor <= bus.b;
    end else if (state == CALC) begin
      cnt     <= cnt + CW'(1);
      acc     <= acc_nxt;
      mcand   <= mcand_nxt;
      mplier  <= mplier_nxt;
      rem     <= rem_nxt;
      quot    <= quot_nxt;
    end
  end

  // Architectural HI/LO, written only on the final iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      dbz_q <= 1'b0;
    end else if (commit) begin
      if (op_q) begin
        hi_q <= rem_nxt;
        lo_q <= quot_nxt;
      end else begin
        hi_q <= acc_nxt[2*WIDTH-1:WIDTH];
        lo_q <= acc_nxt[WIDTH-1:0];
      end
      dbz_q <= op_q && (divisor == '0);
    end
  end

  assign bus.busy        = (state == CALC);
  assign bus.stall       = (state == CALC);
  assign bus.done        = (state == DONE);
  assign bus.div_by_zero = (state == DONE) && dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vector table plus hand-written sequences
// for back-to-back start, ignored start and mid-operation reset.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();
  muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat_full;
    int           lat_eo;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive at a negedge; start is sampled at the following rising edge.
  task automatic launch(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = ~op;
    bus.a     = $urandom();
    bus.b     = $urandom();
  endtask

  // Counts cycles after the start edge until done; returns at the negedge
  // of the done cycle. bad counts protocol violations seen on the way.
  task automatic wait_done(input int inject, output int lat, output int bad);
    logic [W-1:0] hi0, lo0;
    hi0 = bus.hi;
    lo0 = bus.lo;
    lat = -1;
    bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.stall !== bus.busy) bad++;
      if (bus.done === 1'b1) begin
        lat = c;
        if (bus.busy !== 1'b0) bad++;
        break;
      end
      if (bus.busy !== 1'b1) bad++;
      if (bus.div_by_zero !== 1'b0) bad++;
      if (bus.hi !== hi0 || bus.lo !== lo0) bad++;
      if (inject > 0) begin
        bus.start = (c == inject);
        if (c == inject) begin
          bus.a = 32'd1;
          bus.b = 32'd1;
        end
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic check_idle_after(input string name);
    @(negedge clk);
    check(name, {62'd0, bus.done, bus.busy}, 64'd0);
  endtask

  int lat, bad, exp_lat, inj, seen;

  initial begin
    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 33};
    vecs[1] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, 33};
    vecs[2] = '{1'b1, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 33, 33};
    vecs[3] = '{1'b0, 32'd5,        32'd3,        32'd0,        32'd15,       1'b0, 33, 3};
    vecs[4] = '{1'b0, 32'd9,        32'd0,        32'd0,        32'd0,        1'b0, 33, 2};
    vecs[5] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33, 18};
    vecs[6] = '{1'b1, 32'd7,        32'd100,      32'd7,        32'd0,        1'b0, 33, 33};
    vecs[7] = '{1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 33, 33};
    vecs[8] = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 33, 6};

    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", {60'd0, bus.busy, bus.stall, bus.done, bus.div_by_zero}, 64'd0);
    check("reset_hi", {32'd0, bus.hi}, 64'd0);
    check("reset_lo", {32'd0, bus.lo}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
`ifdef MULDIV_EARLY_OUT_EN
      exp_lat = vecs[i].lat_eo;
`else
      exp_lat = vecs[i].lat_full;
`endif
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, lat, bad);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat));
      check($sformatf("v%0d_hi", i), {32'd0, bus.hi}, {32'd0, vecs[i].hi});
      check($sformatf("v%0d_lo", i), {32'd0, bus.lo}, {32'd0, vecs[i].lo});
      check($sformatf("v%0d_dbz", i), {63'd0, bus.div_by_zero}, {63'd0, vecs[i].dbz});
      check($sformatf("v%0d_protocol", i), 64'(bad), 64'd0);
      check_idle_after($sformatf("v%0d_single_done", i));
    end

    // Back-to-back: second DIVU launched in the DONE cycle of the first.
    launch(1'b1, 32'd100, 32'd7);
    wait_done(0, lat, bad);
    check("b2b_first_latency", 64'(lat), 64'd33);
    check("b2b_first_lo", {32'd0, bus.lo}, 64'd14);
    check("b2b_first_hi", {32'd0, bus.hi}, 64'd2);
    launch(1'b1, 32'h80000000, 32'd3);
    wait_done(0, lat, bad);
    check("b2b_second_latency", 64'(lat), 64'd33);
    check("b2b_second_lo", {32'd0, bus.lo}, 64'h2AAAAAAA);
    check("b2b_second_hi", {32'd0, bus.hi}, 64'd2);
    check("b2b_protocol", 64'(bad), 64'd0);
    check_idle_after("b2b_single_done");

    // Start asserted while busy must be ignored.
`ifdef MULDIV_EARLY_OUT_EN
    inj = 2;
    exp_lat = 4;
`else
    inj = 9;
    exp_lat = 33;
`endif
    launch(1'b0, 32'd6, 32'd7);
    wait_done(inj, lat, bad);
    check("ignore_latency", 64'(lat), 64'(exp_lat));
    check("ignore_hi", {32'd0, bus.hi}, 64'd0);
    check("ignore_lo", {32'd0, bus.lo}, 64'd42);
    check("ignore_protocol", 64'(bad), 64'd0);
    check_idle_after("ignore_single_done");

    // Reset mid-operation discards it and clears HI/LO.
    launch(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    check("midrst_hi", {32'd0, bus.hi}, 64'd0);
    check("midrst_lo", {32'd0, bus.lo}, 64'd0);
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    check("midrst_no_done", 64'(seen), 64'd0);
`ifdef MULDIV_EARLY_OUT_EN
    exp_lat = 4;
`else
    exp_lat = 33;
`endif
    launch(1'b0, 32'd3, 32'd5);
    wait_done(0, lat, bad);
    check("postrst_latency", 64'(lat), 64'(exp_lat));
    check("postrst_lo", {32'd0, bus.lo}, 64'd15);
    check("postrst_hi", {32'd0, bus.hi}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
